// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and op classification shared by alu_arbiter
package alu_pkg;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_SLTU;
  endfunction

  function automatic logic is_arith(input logic [3:0] op);
    return op == OP_ADD || op == OP_SUB;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; pointer remembers the last requester granted and accepted
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       acc_i,
  output logic [1:0] gnt_o
);
  logic last_q, last_d;
  always_comb begin
    gnt_o = !en_i ? 2'b00 : (&req_i) ? (last_q ? 2'b01 : 2'b10) : req_i;
    last_d = acc_i ? gnt_o[1] : last_q;
  end
  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else last_q <= last_d;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters, one transaction in flight,
// latching operands for the ALU and holding the captured result until handshaken.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_rs1,
  input  logic [DATA_W-1:0] req0_rs2,
  input  logic [DATA_W-1:0] req1_rs1,
  input  logic [DATA_W-1:0] req1_rs2,
  input  logic [3:0]        req0_control,
  input  logic [3:0]        req1_control,
  output logic [DATA_W-1:0] alu_rs1,
  output logic [DATA_W-1:0] alu_rs2,
  output logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_rd,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rd,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic              rsp_overflow,
  output logic              rsp_err
);
  state_t state_q;
  logic [1:0] gnt;
  logic acc, id_q, ill_q, rsp_valid_q, rsp_id_q, rsp_zero_q, rsp_carry_q, rsp_ovf_q, rsp_err_q;
  logic [DATA_W-1:0] alu_rs1_q, alu_rs2_q, rsp_rd_q, rs1_d, rs2_d, rd_d;
  logic [3:0] alu_ctl_q, ctl_d;
  logic carry_d, ovf_d, unused_zero;

  rr_arb2 u_arb (
    .clk  (clk),
    .reset(reset),
    .req_i(req_valid),
    .en_i (state_q == IDLE && !reset),
    .acc_i(acc),
    .gnt_o(gnt)
  );

  // zero is derived from the captured result so illegal ops and every opcode agree
  assign unused_zero = alu_zero;
  assign req_ready = gnt;
  assign acc = |gnt;

  always_comb begin
    rs1_d = gnt[1] ? req1_rs1 : req0_rs1;
    rs2_d = gnt[1] ? req1_rs2 : req0_rs2;
    ctl_d = gnt[1] ? req1_control : req0_control;
    rd_d = ill_q ? '0 : alu_rd;
    carry_d = !ill_q && is_arith(alu_ctl_q) && alu_carry;
    ovf_d = !ill_q && is_arith(alu_ctl_q) && alu_overflow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q <= 1'b0;
      ill_q <= 1'b0;
      alu_rs1_q <= '0;
      alu_rs2_q <= '0;
      alu_ctl_q <= OP_AND;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= 1'b0;
      rsp_rd_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_ovf_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (acc) begin
          alu_rs1_q <= rs1_d;
          alu_rs2_q <= rs2_d;
          alu_ctl_q <= is_legal(ctl_d) ? ctl_d : alu_ctl_q;
          ill_q <= !is_legal(ctl_d);
          id_q <= gnt[1];
          state_q <= EXEC;
        end
        EXEC: begin
          rsp_rd_q <= rd_d;
          rsp_zero_q <= rd_d == '0;
          rsp_carry_q <= carry_d;
          rsp_ovf_q <= ovf_d;
          rsp_err_q <= ill_q;
          rsp_id_q <= id_q;
          rsp_valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_rs1 = alu_rs1_q;
  assign alu_rs2 = alu_rs2_q;
  assign alu_control = alu_ctl_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_rd = rsp_rd_q;
  assign rsp_zero = rsp_zero_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_err = rsp_err_q;
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 The block SHALL have ports req_valid, input, 2, one request-valid bit per requester (bit0 = requester 0).
REQ-005 The block SHALL have ports req_ready, output, 2, one request-accept bit per requester.
REQ-006 The block SHALL have ports req0_rs1/req0_rs2 and req1_rs1/req1_rs2, input, DATA_W each; signed operands.
REQ-007 The block SHALL have ports req0_control/req1_control, input, 4 each; the ALU op code (0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA, 1000 SLT, 1001 SLTU).
REQ-008 The block SHALL have ports alu_rs1/alu_rs2, output, DATA_W; alu_control, output, 4; these drive the shared ALU.
REQ-009 The block SHALL have ports alu_rd, input, DATA_W; alu_zero/alu_carry/alu_overflow, input, 1 each; these return ALU results.
REQ-010 The block SHALL have ports rsp_valid, output, 1; rsp_ready, input, 1; rsp_id, output, 1 (requester served); rsp_rd, output, DATA_W; rsp_zero, rsp_carry, rsp_overflow, rsp_err, output, 1 each.

Function
REQ-011 FSM states: IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-012 IDLE: req_ready equals the arbiter grant (one-hot or zero); elsewhere req_ready = 2'b00.
REQ-013 Acceptance: on a cycle with req_valid[i] & req_ready[i], latch that requester's rs1/rs2/control and its id, and move IDLE->EXEC.
REQ-014 Arbitration: round-robin; when both requesters are valid, grant the one not served last; when one is valid, grant it regardless of history.
REQ-015 The last-served pointer SHALL update only on acceptance.
REQ-016 EXEC: alu_rs1/alu_rs2/alu_control SHALL be driven from the latched registers; at the end of EXEC capture the result into the response registers and go to RESP.
REQ-017 In IDLE and RESP, the alu_* outputs SHALL hold their last latched values; the ALU input must not glitch.
REQ-018 RESP: rsp_valid = 1; the response registers hold stable until rsp_valid & rsp_ready, then go to IDLE.
REQ-019 Latency: accept in cycle N -> rsp_valid in cycle N+2; next acceptance no earlier than the cycle after the response handshake.
REQ-020 rsp_zero = (captured alu_rd == 0) for every op.
REQ-021 rsp_carry/rsp_overflow = alu_carry/alu_overflow for ADD and SUB only; forced 0 for all other ops.
REQ-022 Illegal control (1010-1111): still accepted. EXEC captures rsp_rd = 0, rsp_zero = 1, carry/overflow = 0, rsp_err = 1. alu_control is not updated to the illegal code. rsp_err = 0 for legal ops.
REQ-023 A requester dropping req_valid before acceptance SHALL NOT be granted; requests are not queued.

Reset
REQ-024 When reset is high at a clock edge: state = IDLE, rsp_valid = 0, req_ready = 0 for that cycle, rsp_* data and flags = 0, rsp_id = 0, alu_* = 0 (control = AND), last-served pointer = 1 (requester 0 wins first tie).
REQ-025 Reset mid-transaction (EXEC or RESP) SHALL abandon it; no response is produced for it.

Structure
REQ-026 A shared package alu_pkg SHALL hold the 4-bit op-code constants, the FSM state enum, and an is_legal/is_arith helper.
REQ-027 A single sub-module rr_arb2 (2-way round-robin, registered pointer) SHALL implement REQ-014/015; all else lives in alu_arbiter.

Verification
REQ-028 Single request: req0 ADD rs1=5, rs2=7, valid at cycle 0 -> accepted at cycle 0. At cycle 2: rsp_valid=1, rsp_id=0, rsp_rd=12, zero=0, carry=0, overflow=0, err=0.
REQ-029 Tie after reset: both valid (req0 SUB 3-3, req1 OR 1|2), rsp_ready=1 -> req0 served first (rd=0, zero=1, carry from ALU). Then req1 is served (rd=3, zero=0, carry=0, overflow=0).
REQ-030 Fairness: both held valid for 8 transactions -> rsp_id sequence 0,1,0,1,0,1,0,1.
REQ-031 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and all rsp_* stable, req_ready=0. A new request is accepted the cycle after rsp_ready rises.
REQ-032 Illegal op: req1 control=1100 -> rsp_err=1, rsp_rd=0, rsp_zero=1, alu_control unchanged.
REQ-033 Flag masking and reset: ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> overflow=1. SLL with the ALU driving overflow=1 -> rsp_overflow=0. Reset asserted during EXEC -> next cycle IDLE, rsp_valid=0, and no response for the aborted op.
